// File: rtl/port_arbiter2.sv
// Two-port round-robin arbiter with locked grants, back-to-back hand-off and a registered payload mux select.
// Optional grant watchdog is built when PORT_ARBITER2_TIMEOUT_EN is defined.
module mux2 #(
    parameter int W = 32
) (
    input  logic         s,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    assign y = s ? b : a;
endmodule

module port_arbiter2 #(
    parameter int n       = 32,
    parameter int TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0,
    input  logic         req1,
    input  logic [n-1:0] d0,
    input  logic [n-1:0] d1,
    input  logic         done,
    output logic         gnt0,
    output logic         gnt1,
    output logic         sel,
    output logic [n-1:0] y,
    output logic         busy,
    output logic         timeout,
    output logic [1:0]   state_dbg,
    output logic         last_dbg
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_q, sel_q;
    logic   expire, release_now, entry;

`ifdef PORT_ARBITER2_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q;
    logic          timeout_q;

    // done on the expiry cycle wins: that is a normal completion, not a timeout.
    assign expire = (state_q != IDLE) && !done && (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= expire;
            if (entry)
                cnt_q <= '0;
            else if (state_q != IDLE && !done)
                cnt_q <= cnt_q + CW'(1);
        end
    end

    assign timeout = timeout_q;
`else
    wire unused_timeout_cfg = |TIMEOUT;
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    assign release_now = (state_q != IDLE) && (done || expire);

    // A release arbitrates on the same edge: the other side first, then re-grant, else idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req0 && req1)
                    state_d = last_q ? GRANT0 : GRANT1;
                else if (req0)
                    state_d = GRANT0;
                else if (req1)
                    state_d = GRANT1;
            end
            GRANT0: begin
                if (release_now) begin
                    if (req1)
                        state_d = GRANT1;
                    else if (req0)
                        state_d = GRANT0;
                    else
                        state_d = IDLE;
                end
            end
            GRANT1: begin
                if (release_now) begin
                    if (req0)
                        state_d = GRANT0;
                    else if (req1)
                        state_d = GRANT1;
                    else
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign entry = (state_d != IDLE) && ((state_q == IDLE) || release_now);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (entry) begin
                last_q <= (state_d == GRANT1);
                sel_q  <= (state_d == GRANT1);
            end
        end
    end

    assign gnt0      = (state_q == GRANT0);
    assign gnt1      = (state_q == GRANT1);
    assign busy      = gnt0 | gnt1;
    assign sel       = sel_q;
    assign state_dbg = state_q;
    assign last_dbg  = last_q;

    mux2 #(.W(n)) u_mux (
        .s (sel_q),
        .a (d0),
        .b (d1),
        .y (y)
    );
endmodule

// File: tb/tb_port_arbiter2.sv
// Self-checking bench for port_arbiter2: directed scenarios plus random traffic against a behavioural model.
// Expectations follow PORT_ARBITER2_TIMEOUT_EN the same way the design build does.
module tb_port_arbiter2;
    localparam int N   = 32;
    localparam int TMO = 15;
`ifdef PORT_ARBITER2_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset, req0, req1, done;
    logic [N-1:0] d0, d1, y;
    logic         gnt0, gnt1, sel, busy, timeout, last_dbg;
    logic [1:0]   state_dbg;

    port_arbiter2 #(.n(N), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .d0        (d0),
        .d1        (d1),
        .done      (done),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .sel       (sel),
        .y         (y),
        .busy      (busy),
        .timeout   (timeout),
        .state_dbg (state_dbg),
        .last_dbg  (last_dbg)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: owner is -1 when nobody holds the resource; held counts cycles the current grant has been open.
    int           m_owner = -1;
    bit           m_last  = 1'b1;
    bit           m_sel   = 1'b0;
    bit           m_tmo   = 1'b0;
    int           m_held  = 0;
    logic [N-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_enter(input int who);
        m_owner = who;
        m_last  = who[0];
        m_sel   = who[0];
        m_held  = 1;
    endtask

    task automatic model_step(input bit r, input bit q0, input bit q1, input bit dn);
        bit rq[2];
        bit expired;
        int other;
        rq[0] = q0;
        rq[1] = q1;
        if (r) begin
            m_owner = -1;
            m_last  = 1'b1;
            m_sel   = 1'b0;
            m_tmo   = 1'b0;
            m_held  = 0;
            return;
        end
        m_tmo = 1'b0;
        if (m_owner < 0) begin
            if (q0 && q1)      model_enter(m_last ? 0 : 1);
            else if (q0)       model_enter(0);
            else if (q1)       model_enter(1);
        end else begin
            expired = TMO_EN && !dn && (m_held == TMO);
            if (dn || expired) begin
                m_tmo = expired;
                other = 1 - m_owner;
                if (rq[other])        model_enter(other);
                else if (rq[m_owner]) model_enter(m_owner);
                else                  m_owner = -1;
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic check_all();
        logic [N-1:0] ey;
        ey = exp_q.pop_front();
        chk("gnt0", N'(gnt0), N'(m_owner == 0));
        chk("gnt1", N'(gnt1), N'(m_owner == 1));
        chk("busy", N'(busy), N'(m_owner >= 0));
        chk("sel", N'(sel), N'(m_sel));
        chk("timeout", N'(timeout), N'(m_tmo));
        chk("last", N'(last_dbg), N'(m_last));
        chk("y", y, ey);
    endtask

    task automatic cycle_d(input bit r, input bit q0, input bit q1, input bit dn,
                           input logic [N-1:0] a, input logic [N-1:0] b);
        reset = r;
        req0  = q0;
        req1  = q1;
        done  = dn;
        d0    = a;
        d1    = b;
        @(posedge clk);
        model_step(r, q0, q1, dn);
        exp_q.push_back(m_sel ? b : a);
        #1;
        check_all();
    endtask

    task automatic cycle(input bit r, input bit q0, input bit q1, input bit dn);
        cycle_d(r, q0, q1, dn, N'($urandom), N'($urandom));
    endtask

    int  idle_cnt, switches, prev_owner, cur_owner;
    int  held, tmo_seen;
    bit  released, rel_gnt1, rel_tmo;

    initial begin
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; done = 1'b0; d0 = '0; d1 = '0;
        #1;

        // Reset state, then a single request from port 0.
        cycle(1, 0, 0, 0);
        cycle(1, 1, 1, 1);
        chk("reset_last", N'(last_dbg), N'(1));
        cycle_d(0, 1, 0, 0, 32'hA5A5_0001, 32'h0000_BEEF);
        chk("single_gnt0", N'(gnt0), N'(1));
        chk("single_sel", N'(sel), N'(0));
        chk("single_y", y, 32'hA5A5_0001);

        // Both requesting, done every third cycle: strict alternation with no idle gap.
        cycle(1, 0, 0, 0);
        cycle(0, 1, 1, 0);
        idle_cnt = 0; switches = 0; prev_owner = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(0, 1, 1, (i % 3) == 2);
            if (!busy) idle_cnt++;
            cur_owner = gnt1 ? 1 : 0;
            if (cur_owner != prev_owner) switches++;
            prev_owner = cur_owner;
        end
        chk("alt_idle", N'(idle_cnt), N'(0));
        chk("alt_switches", N'(switches), N'(4));

        // Locked grant on port 1 survives a dropped request until done.
        cycle(0, 0, 1, 1);
        chk("lock_enter_gnt1", N'(gnt1), N'(1));
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 0, 0);
            chk("lock_hold_gnt1", N'(gnt1), N'(1));
        end
        cycle(0, 0, 0, 1);
        chk("lock_release_busy", N'(busy), N'(0));
        chk("lock_release_sel", N'(sel), N'(1));

        // Reset in the middle of a grant.
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        chk("mid_pre_gnt0", N'(gnt0), N'(1));
        cycle(1, 1, 1, 1);
        chk("mid_rst_gnt0", N'(gnt0), N'(0));
        chk("mid_rst_last", N'(last_dbg), N'(1));
        chk("mid_rst_timeout", N'(timeout), N'(0));
        cycle(0, 1, 1, 0);
        chk("mid_after_gnt0", N'(gnt0), N'(1));

        // Grant held with done never asserted.
        cycle(1, 0, 0, 0);
        cycle(0, 1, 1, 0);
        held = 1; tmo_seen = 0; released = 1'b0; rel_gnt1 = 1'b0; rel_tmo = 1'b0;
        for (int i = 0; i < 110; i++) begin
            cycle(0, 1, 1, 0);
            if (timeout) tmo_seen++;
            if (!released) begin
                if (gnt0) held++;
                else begin
                    released = 1'b1;
                    rel_gnt1 = gnt1;
                    rel_tmo  = timeout;
                end
            end
        end
`ifdef PORT_ARBITER2_TIMEOUT_EN
        chk("wd_hold_len", N'(held), N'(TMO));
        chk("wd_release_gnt1", N'(rel_gnt1), N'(1));
        chk("wd_release_pulse", N'(rel_tmo), N'(1));
        chk("wd_pulse_count", N'(tmo_seen), N'(7));
`else
        chk("nowd_released", N'(released), N'(0));
        chk("nowd_hold_100", N'(held >= 100), N'(1));
        chk("nowd_pulse_count", N'(tmo_seen), N'(0));
`endif

        // Random traffic against the model.
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
        end
        // Long random stretches with rare done exercise the watchdog too.
        for (int i = 0; i < 200; i++) begin
            cycle(1'b0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 24) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
